// File: rtl/vga_sync_rx.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_rx
// Description : VGA stream receiver. Registers hsync/vsync/valid/RGB,
//               recovers pixel coordinates, measures line and frame timing
//               against the expected mode, tracks lock and forwards active
//               pixels with their (h_addr, v_addr) two clocks after input.
//               Optional per-frame checksum: define VGA_RX_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_rx #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        valid,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic        pix_valid,
  output logic [23:0] pix_data,
  output logic [9:0]  h_addr,
  output logic [9:0]  v_addr,
  output logic        line_start,
  output logic        frame_start,
  output logic        locked,
  output logic [10:0] h_meas,
  output logic [9:0]  v_meas,
  output logic        err,
  output logic [23:0] frame_sum
);

  localparam logic [1:0]  ST_SEARCH  = 2'd0;
  localparam logic [1:0]  ST_MEASURE = 2'd1;
  localparam logic [1:0]  ST_LOCKED  = 2'd2;

  localparam logic [9:0]  H_ACT_W   = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT_W   = 10'(V_ACTIVE);
  localparam logic [10:0] H_TOT_W   = 11'(H_TOTAL);
  localparam logic [9:0]  V_TOT_W   = 10'(V_TOTAL);
  localparam logic [10:0] H_CNT_MAX = 11'h7FF;
  localparam logic [9:0]  V_CNT_MAX = 10'h3FF;

  // input stage
  logic        r_hs, r_vs, r_hs_d, r_vs_d, r_val;
  logic [23:0] r_rgb;
  // timing measurement
  logic [10:0] r_h_cnt;
  logic [9:0]  r_v_cnt;
  logic        r_h_seen, r_frame_bad;
  // addressing
  logic [9:0]  r_h_addr, r_v_addr;
  logic        r_line_pix;
  // lock tracking
  logic [1:0]  r_state, r_miss;

  logic        w_h_edge, w_v_edge, w_h_sat, w_ovr, w_pix_ok;
  logic        w_line_bad, w_frame_bad, w_v_mis, w_err, w_fbad_nxt;
  logic [10:0] w_h_meas_new;
  logic [9:0]  w_v_line, w_h_cur, w_v_cur;
  logic [1:0]  w_state_nxt, w_miss_nxt;

  // Register every input once; keep the previous sync levels for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs   <= ~SYNC_POL;
      r_vs   <= ~SYNC_POL;
      r_hs_d <= ~SYNC_POL;
      r_vs_d <= ~SYNC_POL;
      r_val  <= 1'b0;
      r_rgb  <= '0;
    end else begin
      r_hs   <= hsync;
      r_vs   <= vsync;
      r_hs_d <= r_hs;
      r_vs_d <= r_vs;
      r_val  <= valid;
      r_rgb  <= {vga_r, vga_g, vga_b};
    end
  end

  assign w_h_edge = (r_hs == SYNC_POL) && (r_hs_d != SYNC_POL);
  assign w_v_edge = (r_vs == SYNC_POL) && (r_vs_d != SYNC_POL);

  // Line length is edge-to-edge, so the count closing a line includes this clock
  assign w_h_meas_new = (r_h_cnt == H_CNT_MAX) ? H_CNT_MAX : r_h_cnt + 11'd1;
  assign w_h_sat      = !w_h_edge && (r_h_cnt == H_CNT_MAX - 11'd1);
  // Line count including an hsync edge on this cycle (line closes before frame)
  assign w_v_line     = (w_h_edge && r_v_cnt != V_CNT_MAX) ? r_v_cnt + 10'd1 : r_v_cnt;

  // Current pixel address with this cycle's sync edges already applied
  assign w_h_cur  = w_h_edge ? '0 : r_h_addr;
  assign w_v_cur  = w_v_edge ? '0 :
                    (w_h_edge && r_line_pix && r_v_addr != V_ACT_W) ? r_v_addr + 10'd1 : r_v_addr;
  assign w_ovr    = r_val && (w_h_cur == H_ACT_W || w_v_cur == V_ACT_W);
  assign w_pix_ok = r_val && !w_ovr;

  // The first hsync edge after reset or sync loss has no valid preceding line
  assign w_line_bad  = w_h_edge && r_h_seen && (w_h_meas_new != H_TOT_W);
  assign w_v_mis     = w_v_line != V_TOT_W;
  assign w_frame_bad = r_frame_bad || w_line_bad || w_v_mis;

  // Sync counters and address counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt    <= '0;
      r_v_cnt    <= '0;
      r_h_seen   <= 1'b0;
      r_h_addr   <= '0;
      r_v_addr   <= '0;
      r_line_pix <= 1'b0;
    end else begin
      if (w_h_edge)                  r_h_cnt <= '0;
      else if (r_h_cnt != H_CNT_MAX) r_h_cnt <= r_h_cnt + 11'd1;
      r_v_cnt    <= w_v_edge ? '0 : w_v_line;
      r_h_seen   <= w_h_sat ? 1'b0 : (r_h_seen | w_h_edge);
      r_h_addr   <= w_pix_ok ? w_h_cur + 10'd1 : w_h_cur;
      r_v_addr   <= w_v_cur;
      r_line_pix <= w_h_edge ? r_val : (r_line_pix | r_val);
    end
  end

  // Lock state machine: next state, miss count and error strobe
  always_comb begin
    w_state_nxt = r_state;
    w_miss_nxt  = r_miss;
    w_fbad_nxt  = r_frame_bad | w_line_bad;
    w_err       = w_ovr;
    if (w_h_sat) begin
      w_state_nxt = ST_SEARCH;
      w_miss_nxt  = '0;
      w_fbad_nxt  = 1'b0;
      w_err       = 1'b1;
    end else begin
      case (r_state)
        ST_SEARCH: begin
          if (w_v_edge) begin
            w_state_nxt = ST_MEASURE;
            w_fbad_nxt  = 1'b0;
          end
        end
        ST_MEASURE: begin
          if (w_v_edge) begin
            w_fbad_nxt = 1'b0;
            w_miss_nxt = '0;
            if (w_frame_bad) begin
              w_state_nxt = ST_SEARCH;
              w_err       = 1'b1;
            end else begin
              w_state_nxt = ST_LOCKED;
            end
          end
        end
        ST_LOCKED: begin
          if (w_line_bad) w_err = 1'b1;
          if (w_v_edge) begin
            w_fbad_nxt = 1'b0;
            if (w_v_mis) w_err = 1'b1;
            if (!w_frame_bad) begin
              w_miss_nxt = '0;
            end else if (r_miss != 2'd0) begin
              w_state_nxt = ST_SEARCH;
              w_miss_nxt  = '0;
            end else begin
              w_miss_nxt = r_miss + 2'd1;
            end
          end
        end
        default: w_state_nxt = ST_SEARCH;
      endcase
    end
  end

  // Lock state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_SEARCH;
      r_miss      <= '0;
      r_frame_bad <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_miss      <= w_miss_nxt;
      r_frame_bad <= w_fbad_nxt;
    end
  end

  assign locked = (r_state == ST_LOCKED);

  // Output stage: second register after the input stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      h_addr      <= '0;
      v_addr      <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      err         <= 1'b0;
      h_meas      <= '0;
      v_meas      <= '0;
    end else begin
      pix_valid   <= w_pix_ok;
      pix_data    <= r_rgb;
      h_addr      <= w_h_cur;
      v_addr      <= w_v_cur;
      line_start  <= w_h_edge;
      frame_start <= w_v_edge;
      err         <= w_err;
      if (w_h_edge) h_meas <= w_h_meas_new;
      if (w_v_edge) v_meas <= w_v_line;
    end
  end

`ifdef VGA_RX_CHECKSUM_EN
  logic [23:0] r_acc;

  // Wrap-around sum of accepted pixels; published and restarted on vsync edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      frame_sum <= '0;
    end else if (w_v_edge) begin
      frame_sum <= r_acc;
      r_acc     <= w_pix_ok ? r_rgb : '0;
    end else if (w_pix_ok) begin
      r_acc     <= r_acc + r_rgb;
    end
  end
`else
  assign frame_sum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_rx
// Description : Scoreboard bench for vga_sync_rx on a reduced 8x4 mode
//               (12 clocks/line, 7 lines/frame, active-low syncs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_rx;

  localparam logic SP = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsync, vsync, valid;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        pix_valid, line_start, frame_start, locked, err;
  logic [23:0] pix_data, frame_sum;
  logic [9:0]  h_addr, v_addr, v_meas;
  logic [10:0] h_meas;

  vga_sync_rx #(
    .H_ACTIVE(8), .V_ACTIVE(4), .H_TOTAL(12), .V_TOTAL(7), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .valid(valid),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .pix_valid(pix_valid), .pix_data(pix_data), .h_addr(h_addr), .v_addr(v_addr),
    .line_start(line_start), .frame_start(frame_start), .locked(locked),
    .h_meas(h_meas), .v_meas(v_meas), .err(err), .frame_sum(frame_sum)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int h; int v; logic [23:0] d; } pix_t;
  typedef struct { int cyc; bit lk; bit chk; int h; int v; logic [23:0] s; } frm_t;

  pix_t        pq[$];
  int          lq[$];
  frm_t        fq[$];
  pix_t        pe;
  frm_t        fe;
  int          le;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          err_seen = 0;
  int          exp_err = 0;
  logic [23:0] run_sum = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected items whenever the DUT presents an output
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (err === 1'b1) err_seen++;
      if (pix_valid !== 1'b0) begin
        if (pq.size() == 0) chk("pix_unexpected", pix_valid, 0);
        else begin
          pe = pq.pop_front();
          chk("pix_cycle", cyc, pe.cyc);
          chk("h_addr", h_addr, pe.h);
          chk("v_addr", v_addr, pe.v);
          chk("pix_data", pix_data, pe.d);
        end
      end
      if (line_start !== 1'b0) begin
        if (lq.size() == 0) chk("line_unexpected", line_start, 0);
        else begin
          le = lq.pop_front();
          chk("line_cycle", cyc, le);
        end
      end
      if (frame_start !== 1'b0) begin
        if (fq.size() == 0) chk("frame_unexpected", frame_start, 0);
        else begin
          fe = fq.pop_front();
          chk("frame_cycle", cyc, fe.cyc);
          chk("locked", locked, fe.lk);
          if (fe.chk) begin
            chk("h_meas", h_meas, fe.h);
            chk("v_meas", v_meas, fe.v);
          end
          chk("frame_sum", frame_sum, fe.s);
        end
      end
    end
  end

  task automatic step(input bit hs_a, input bit vs_a, input bit val, input logic [23:0] d);
    hsync = hs_a ? SP : ~SP;
    vsync = vs_a ? SP : ~SP;
    valid = val;
    {vga_r, vga_g, vga_b} = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  // One frame: 7 lines of hlen clocks; hsync clocks 0-1, pixels at 2-9 of
  // lines 2-5, vsync on lines 0-1. Outputs expected 2 clocks after drive.
  task automatic frame(input int hlen, input bit lk, input bit chkm, input int eh,
                       input int ev, input bit ovr, input int abort_ln);
    frm_t        f;
    pix_t        p;
    logic [23:0] d;
    bit          pix, extra;
    for (int ln = 0; ln < 7; ln++) begin
      for (int c = 0; c < hlen; c++) begin
        if (ln == abort_ln && c == 5) return;
        pix   = (ln >= 2) && (ln <= 5) && (c >= 2) && (c < 10);
        extra = ovr && (ln == 2) && (c == 10);
        d     = 24'h0;
        if (c == 0) lq.push_back(cyc + 2);
        if (c == 0 && ln == 0) begin
          f.cyc = cyc + 2; f.lk = lk; f.chk = chkm; f.h = eh; f.v = ev;
`ifdef VGA_RX_CHECKSUM_EN
          f.s = run_sum;
`else
          f.s = 24'h0;
`endif
          fq.push_back(f);
          run_sum = '0;
        end
        if (pix) begin
          d = {8'(c - 2), 8'(ln - 2), 8'h5A};
          p.cyc = cyc + 2; p.h = c - 2; p.v = ln - 2; p.d = d;
          pq.push_back(p);
          run_sum = run_sum + d;
        end
        if (extra) d = 24'hABCDEF;
        step(c < 2, ln < 2, pix | extra, d);
      end
    end
  endtask

  task automatic frame_err(input string nm, input int hlen, input bit lk, input bit chkm,
                           input int eh, input int ev, input bit ovr, input int n_err);
    frame(hlen, lk, chkm, eh, ev, ovr, -1);
    exp_err += n_err;
    chk(nm, err_seen, exp_err);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_pix_valid"}, pix_valid, 0);
    chk({nm, "_pix_data"}, pix_data, 0);
    chk({nm, "_h_addr"}, h_addr, 0);
    chk({nm, "_v_addr"}, v_addr, 0);
    chk({nm, "_line_start"}, line_start, 0);
    chk({nm, "_frame_start"}, frame_start, 0);
    chk({nm, "_locked"}, locked, 0);
    chk({nm, "_h_meas"}, h_meas, 0);
    chk({nm, "_v_meas"}, v_meas, 0);
    chk({nm, "_err"}, err, 0);
    chk({nm, "_frame_sum"}, frame_sum, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    hsync = ~SP; vsync = ~SP; valid = 1'b0;
    {vga_r, vga_g, vga_b} = 24'h0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    idle(5);

    // acquire lock: MEASURE after first vsync edge, LOCKED on the second
    frame_err("err_f1", 12, 1'b0, 1'b0, 0, 0, 1'b0, 0);
    frame_err("err_f2", 12, 1'b1, 1'b1, 12, 7, 1'b0, 0);
    // overrun pixel at h_addr == H_ACTIVE
    frame_err("err_f3_ovr", 12, 1'b1, 1'b1, 12, 7, 1'b1, 1);
    // one bad frame of 13-clock lines: stays locked
    frame_err("err_f4_bad", 13, 1'b1, 1'b1, 12, 7, 1'b0, 6);
    frame_err("err_f5", 12, 1'b1, 1'b1, 13, 7, 1'b0, 1);
    frame_err("err_f6", 12, 1'b1, 1'b1, 12, 7, 1'b0, 0);
    // two consecutive bad frames: back to SEARCH
    frame_err("err_f7_bad", 13, 1'b1, 1'b1, 12, 7, 1'b0, 6);
    frame_err("err_f8_bad", 13, 1'b1, 1'b1, 13, 7, 1'b0, 7);
    frame_err("err_f9", 12, 1'b0, 1'b1, 13, 7, 1'b0, 1);
    frame_err("err_f10", 12, 1'b0, 1'b1, 12, 7, 1'b0, 0);
    frame_err("err_f11", 12, 1'b1, 1'b1, 12, 7, 1'b0, 0);

    // sync lost: hsync inactive long enough for h_cnt to saturate
    idle(2100);
    exp_err += 1;
    chk("err_sat", err_seen, exp_err);
    chk("locked_after_sat", locked, 0);
    frame_err("err_f12", 12, 1'b0, 1'b1, 2047, 7, 1'b0, 0);
    frame_err("err_f13", 12, 1'b1, 1'b1, 12, 7, 1'b0, 0);

    // reset in the middle of active video
    frame(12, 1'b1, 1'b1, 12, 7, 1'b0, 3);
    rst_n = 1'b0;
    hsync = ~SP; vsync = ~SP; valid = 1'b0;
    pq.delete(); lq.delete(); fq.delete();
    run_sum = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("midrst");
    rst_n = 1'b1;
    idle(5);
    frame_err("err_f15", 12, 1'b0, 1'b0, 0, 0, 1'b0, 0);
    frame_err("err_f16", 12, 1'b1, 1'b1, 12, 7, 1'b0, 0);
    frame_err("err_f17", 12, 1'b1, 1'b1, 12, 7, 1'b0, 0);
    idle(20);

    chk("pix_queue_left", pq.size(), 0);
    chk("line_queue_left", lq.size(), 0);
    chk("frame_queue_left", fq.size(), 0);
    chk("err_final", err_seen, exp_err);
    chk("locked_final", locked, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
